mul_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in EX beside
//  the single-cycle ALU and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/div_iter.sv | 54 +++++
 rtl/mul_div_unit.sv | 157 +++++++++++++++
 tb/tb_mul_div_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, state enum and op-class helpers for mul_div_unit
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'b000;
   localparam logic [2:0] MDU_MULTU = 3'b001;
   localparam logic [2:0] MDU_DIV   = 3'b010;
   localparam logic [2:0] MDU_DIVU  = 3'b011;
   localparam logic [2:0] MDU_MTHI  = 3'b100;
   localparam logic [2:0] MDU_MTLO  = 3'b101;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_t;

   function automatic logic is_mul(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic is_signed(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   function automatic logic is_mt(input logic [2:0] op);
      return (op == MDU_MTHI) || (op == MDU_MTLO);
   endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - unsigned radix-2 restoring divider, one quotient bit per cycle
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] abs_a,
   input  logic [WIDTH-1:0] abs_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH:0]   trial;

   // quot doubles as the dividend shift register; its MSB feeds the partial remainder
   assign trial = {rem, quot[WIDTH-1]} - {1'b0, divisor};
   assign done  = busy && (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         cnt     <= '0;
         divisor <= '0;
         quot    <= '0;
         rem     <= '0;
      end else if (start) begin
         busy    <= 1'b1;
         cnt     <= CW'(WIDTH - 1);
         divisor <= abs_b;
         quot    <= abs_a;
         rem     <= '0;
      end else if (busy) begin
         if (trial[WIDTH]) begin
            rem  <= {rem[WIDTH-2:0], quot[WIDTH-1]};
            quot <= {quot[WIDTH-2:0], 1'b0};
         end else begin
            rem  <= trial[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
         end
         if (cnt == '0)
            busy <= 1'b0;
         else
            cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle multiply/divide unit with HI/LO registers for the EX stage
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             StartE,
   input  logic [2:0]       MDUOpE,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   input  logic             FlushE,
   output logic             BusyE,
   output logic             DoneE,
   output logic [WIDTH-1:0] HIOut,
   output logic [WIDTH-1:0] LOOut
);

   localparam int CNTW = $clog2(MUL_CYCLES + 1);

   mdu_state_t       state;
   logic [CNTW-1:0]  cnt;
   logic             accept;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] prod_pipe [MUL_CYCLES];

   logic             q_neg;
   logic             r_neg;
   logic             b_zero;
   logic [WIDTH-1:0] a_hold;
   logic             div_busy;
   logic             div_done;
   logic [WIDTH-1:0] div_quot;
   logic [WIDTH-1:0] div_rem;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   assign accept = StartE && !FlushE && (state == IDLE) &&
                   (is_mul(MDUOpE) || is_div(MDUOpE) || is_mt(MDUOpE));

   assign a_neg = is_signed(MDUOpE) && SrcAE[WIDTH-1];
   assign b_neg = is_signed(MDUOpE) && SrcBE[WIDTH-1];
   assign abs_a = a_neg ? -SrcAE : SrcAE;
   assign abs_b = b_neg ? -SrcBE : SrcBE;

   // Low 2*WIDTH bits of the product of sign/zero-extended operands serve both variants
   assign ext_a = {{WIDTH{a_neg}}, SrcAE};
   assign ext_b = {{WIDTH{b_neg}}, SrcBE};

   always_ff @(posedge clk) begin
      prod_pipe[0] <= ext_a * ext_b;
      for (int i = 1; i < MUL_CYCLES; i++)
         prod_pipe[i] <= prod_pipe[i-1];
   end

   div_iter #(.WIDTH(WIDTH)) u_div_iter (
      .clk   (clk),
      .rst   (rst),
      .start (accept && is_div(MDUOpE)),
      .abs_a (abs_a),
      .abs_b (abs_b),
      .busy  (div_busy),
      .done  (div_done),
      .quot  (div_quot),
      .rem   (div_rem)
   );

   assign quot_fix = q_neg ? -div_quot : div_quot;
   assign rem_fix  = r_neg ? -div_rem  : div_rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         BusyE  <= 1'b0;
         DoneE  <= 1'b0;
         HIOut  <= '0;
         LOOut  <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         b_zero <= 1'b0;
         a_hold <= '0;
      end else begin
         DoneE <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (MDUOpE == MDU_MTHI) begin
                     HIOut <= SrcAE;
                  end else if (MDUOpE == MDU_MTLO) begin
                     LOOut <= SrcAE;
                  end else if (is_mul(MDUOpE)) begin
                     state <= MUL;
                     BusyE <= 1'b1;
                     cnt   <= CNTW'(MUL_CYCLES - 1);
                  end else begin
                     state  <= DIV;
                     BusyE  <= 1'b1;
                     q_neg  <= a_neg ^ b_neg;
                     r_neg  <= a_neg;
                     b_zero <= (SrcBE == '0);
                     a_hold <= SrcAE;
                  end
               end
            end
            MUL: begin
               if (FlushE) begin
                  state <= IDLE;
                  BusyE <= 1'b0;
                  cnt   <= '0;
               end else if (cnt == '0) begin
                  {HIOut, LOOut} <= prod_pipe[MUL_CYCLES-1];
                  state <= IDLE;
                  BusyE <= 1'b0;
                  DoneE <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DIV: begin
               if (FlushE || (!div_done && !div_busy)) begin
                  state <= IDLE;
                  BusyE <= 1'b0;
               end else if (div_done) begin
                  state <= FIX;
               end
            end
            FIX: begin
               state <= IDLE;
               BusyE <= 1'b0;
               if (!FlushE) begin
                  DoneE <= 1'b1;
                  if (b_zero) begin
                     LOOut <= '1;
                     HIOut <= a_hold;
                  end else begin
                     LOOut <= quot_fix;
                     HIOut <= rem_fix;
                  end
               end
            end
            default: begin
               state <= IDLE;
               BusyE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed and randomised checks of mul_div_unit at WIDTH 32 and 8
module tb_mul_div_unit;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam int MC8 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        s32, f32, busy32, done32;
   logic [2:0]  op32;
   logic [31:0] a32, b32, hi32, lo32;
   logic        s8, f8, busy8, done8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8, hi8, lo8;

   mul_div_unit #(.WIDTH(32), .MUL_CYCLES(2)) u32 (
      .clk(clk), .rst(rst), .StartE(s32), .MDUOpE(op32), .SrcAE(a32), .SrcBE(b32),
      .FlushE(f32), .BusyE(busy32), .DoneE(done32), .HIOut(hi32), .LOOut(lo32));

   mul_div_unit #(.WIDTH(8), .MUL_CYCLES(MC8)) u8 (
      .clk(clk), .rst(rst), .StartE(s8), .MDUOpE(op8), .SrcAE(a8), .SrcBE(b8),
      .FlushE(f8), .BusyE(busy8), .DoneE(done8), .HIOut(hi8), .LOOut(lo8));

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic logic get_busy(input bit w8);
      return w8 ? busy8 : busy32;
   endfunction

   function automatic logic get_done(input bit w8);
      return w8 ? done8 : done32;
   endfunction

   function automatic logic [31:0] get_hi(input bit w8);
      return w8 ? {24'b0, hi8} : hi32;
   endfunction

   function automatic logic [31:0] get_lo(input bit w8);
      return w8 ? {24'b0, lo8} : lo32;
   endfunction

   // Reference built on native 64-bit arithmetic: {hi, lo}
   function automatic logic [63:0] ref_op(input int w, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
      longint unsigned mask, ua, ub, up, minv;
      longint          sa, sb, p;
      logic [63:0]     hi, lo;
      mask = (64'd1 << w) - 64'd1;
      minv = 64'd1 << (w - 1);
      ua = {32'b0, a} & mask;
      ub = {32'b0, b} & mask;
      sa = (ua >= minv) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
      sb = (ub >= minv) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
      hi = '0;
      lo = '0;
      case (op)
         OP_MULT:  begin p = sa * sb; hi = p >>> w; lo = p; end
         OP_MULTU: begin up = ua * ub; hi = up >> w; lo = up; end
         OP_DIV: begin
            if (ub == 0) begin lo = mask; hi = ua; end
            else if (sa == -longint'(minv) && sb == -1) begin lo = minv; hi = 0; end
            else begin lo = sa / sb; hi = sa % sb; end
         end
         OP_DIVU: begin
            if (ub == 0) begin lo = mask; hi = ua; end
            else begin lo = ua / ub; hi = ua % ub; end
         end
         default: ;
      endcase
      return {hi[31:0] & mask[31:0], lo[31:0] & mask[31:0]};
   endfunction

   task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int elat, input string name);
      int lat;
      @(negedge clk);
      if (w8) begin s8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
      else begin s32 = 1'b1; op32 = op; a32 = a; b32 = b; end
      @(negedge clk);
      s8 = 1'b0;
      s32 = 1'b0;
      lat = 0;
      while (get_busy(w8) && lat < 200) begin
         lat++;
         @(negedge clk);
      end
      chk({name, " lat"}, 64'(lat), 64'(elat));
      chk({name, " done"}, 64'(get_done(w8)), 64'd1);
      chk({name, " hi"}, 64'(get_hi(w8)), 64'(ehi));
      chk({name, " lo"}, 64'(get_lo(w8)), 64'(elo));
      @(negedge clk);
      chk({name, " done_off"}, 64'(get_done(w8)), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int lat;
      bit seen;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      logic [63:0] e;

      vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 2};
      vecs[1]  = '{OP_MULTU, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB, 2};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
      vecs[3]  = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        33};
      vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
      vecs[5]  = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33};
      vecs[6]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
      vecs[7]  = '{OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 33};
      vecs[8]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
      vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2};
      vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF, 33};
      vecs[11] = '{OP_DIV,   32'd100,      32'd7,        32'd2,        32'd14,       33};
      vecs[12] = '{OP_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 2};

      rst = 1'b1;
      s32 = 1'b0; f32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
      s8 = 1'b0;  f8 = 1'b0;  op8 = '0;  a8 = '0;  b8 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst busy", 64'(busy32), 64'd0);
      chk("rst done", 64'(done32), 64'd0);
      chk("rst hi", 64'(hi32), 64'd0);
      chk("rst lo", 64'(lo32), 64'd0);
      chk("rst busy8", 64'(busy8), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++)
         run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                vecs[i].lat, $sformatf("vec%0d", i));

      // MTHI / MTLO write at the accept edge with no busy and no done
      @(negedge clk); s32 = 1'b1; op32 = OP_MTHI; a32 = 32'h1234;
      @(negedge clk); s32 = 1'b0;
      chk("mthi hi", 64'(hi32), 64'h1234);
      chk("mthi busy", 64'(busy32), 64'd0);
      chk("mthi done", 64'(done32), 64'd0);
      s32 = 1'b1; op32 = OP_MTLO; a32 = 32'h5678;
      @(negedge clk); s32 = 1'b0;
      chk("mtlo lo", 64'(lo32), 64'h5678);
      chk("mtlo hi", 64'(hi32), 64'h1234);
      @(negedge clk);
      chk("mtlo done", 64'(done32), 64'd0);
      run_op(1'b0, OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 2, "mult_after_mt");

      // Flush at cycle 10 of a divide
      @(negedge clk); s32 = 1'b1; op32 = OP_DIV; a32 = 32'd100; b32 = 32'd7;
      @(negedge clk); s32 = 1'b0;
      repeat (9) @(negedge clk);
      f32 = 1'b1;
      @(negedge clk); f32 = 1'b0;
      chk("flush busy", 64'(busy32), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done32 || busy32) seen = 1'b1;
         @(negedge clk);
      end
      chk("flush no done", 64'(seen), 64'd0);
      chk("flush hi", 64'(hi32), 64'd0);
      chk("flush lo", 64'(lo32), 64'd15);

      // Start together with flush in IDLE is not accepted
      s32 = 1'b1; f32 = 1'b1; op32 = OP_MTHI; a32 = 32'hDEAD;
      @(negedge clk);
      op32 = OP_MULT;
      @(negedge clk);
      s32 = 1'b0; f32 = 1'b0;
      chk("flush start hi", 64'(hi32), 64'd0);
      chk("flush start busy", 64'(busy32), 64'd0);

      // Second start while busy is ignored
      @(negedge clk); s32 = 1'b1; op32 = OP_MULTU; a32 = 32'd2; b32 = 32'd3;
      @(negedge clk);
      lat = busy32 ? 1 : 0;
      op32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7;
      @(negedge clk); s32 = 1'b0;
      while (busy32 && lat < 200) begin
         lat++;
         @(negedge clk);
      end
      chk("ignore lat", 64'(lat), 64'd2);
      chk("ignore hi", 64'(hi32), 64'd0);
      chk("ignore lo", 64'(lo32), 64'd6);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy32) seen = 1'b1;
         @(negedge clk);
      end
      chk("ignore no queue", 64'(seen), 64'd0);
      chk("ignore lo held", 64'(lo32), 64'd6);

      // Reset in the middle of a divide
      s32 = 1'b1; op32 = OP_MTHI; a32 = 32'hA5A5;
      @(negedge clk); op32 = OP_DIV; a32 = 32'hFFFFFFF9; b32 = 32'd2;
      @(negedge clk); s32 = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst busy", 64'(busy32), 64'd0);
      chk("midrst hi", 64'(hi32), 64'd0);
      chk("midrst lo", 64'(lo32), 64'd0);
      chk("midrst done", 64'(done32), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst done after", 64'(done32), 64'd0);
      run_op(1'b0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 2, "multu_after_rst");

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         e = ref_op(32, rop, ra, rb);
         run_op(1'b0, rop, ra, rb, e[63:32], e[31:0], (rop < 2) ? 2 : 33,
                $sformatf("r32_%0d op%0d a=%h b=%h", i, rop, ra, rb));
      end

      run_op(1'b1, OP_DIV, 32'h80, 32'hFF, 32'h0, 32'h80, 9, "w8 min_neg1");
      run_op(1'b1, OP_MULT, 32'h80, 32'h80, 32'h40, 32'h00, MC8, "w8 min_min");
      for (int i = 0; i < 80; i++) begin
         rop = 3'($urandom_range(0, 3));
         ra = {24'b0, 8'($urandom)};
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : {24'b0, 8'($urandom)};
         e = ref_op(8, rop, ra, rb);
         run_op(1'b1, rop, ra, rb, e[63:32], e[31:0], (rop < 2) ? MC8 : 9,
                $sformatf("r8_%0d op%0d a=%h b=%h", i, rop, ra, rb));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
